// File: rtl/bit_stream_encoder.sv
// Signed word to unit-step burst encoder driving a summ accumulator cell.
// Optional BSENC_SYM_CLAMP_EN clamps the most negative input to the symmetric range.
module bit_stream_encoder #(
    parameter int data_width = 3
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [data_width-1:0] iData,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic                  iHold,
    output logic                  oBit,
    output logic                  oEn,
    output logic                  oBusy,
    output logic                  oDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [data_width-1:0] ZERO_V  = {data_width{1'b0}};
    localparam logic [data_width-1:0] ONE_V   = {{(data_width-1){1'b0}}, 1'b1};
    localparam logic [data_width-1:0] MIN_V   = {1'b1, {(data_width-1){1'b0}}};
    localparam logic [data_width-1:0] MAXPOS_V = {1'b0, {(data_width-1){1'b1}}};

    state_t                state_r;
    logic [data_width-1:0] cnt_r;
    logic [data_width-1:0] mag_s;
    logic [data_width-1:0] negMag_s;
    logic [data_width-1:0] cntNext_s;

    // Magnitude of the incoming word (two's-complement negate for negatives)
    always_comb begin
        negMag_s = ~iData + ONE_V;
        mag_s    = iData;
        if (iData[data_width-1]) begin
`ifdef BSENC_SYM_CLAMP_EN
            if (iData == MIN_V) begin
                mag_s = MAXPOS_V;
            end else begin
                mag_s = negMag_s;
            end
`else
            mag_s = negMag_s;
`endif
        end else begin
            mag_s = iData;
        end
    end

    // cnt_r counts steps still owed, including the one currently strobed on oEn
    always_comb begin
        if (oEn) begin
            cntNext_s = cnt_r - ONE_V;
        end else begin
            cntNext_s = cnt_r;
        end
    end

    // Burst FSM with registered outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_r <= IDLE;
            cnt_r   <= ZERO_V;
            oReady  <= 1'b1;
            oBit    <= 1'b0;
            oEn     <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    oDone <= 1'b0;
                    oEn   <= 1'b0;
                    if (iValid && oReady) begin
                        cnt_r  <= mag_s;
                        oReady <= 1'b0;
                        oBusy  <= 1'b1;
                        if (mag_s != ZERO_V) begin
                            state_r <= BURST;
                            oBit    <= ~iData[data_width-1];
                            oEn     <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            oDone   <= 1'b1;
                        end
                    end else begin
                        oReady <= 1'b1;
                        oBusy  <= 1'b0;
                    end
                end
                BURST: begin
                    cnt_r <= cntNext_s;
                    if (cntNext_s == ZERO_V) begin
                        state_r <= DONE;
                        oEn     <= 1'b0;
                        oDone   <= 1'b1;
                    end else begin
                        oEn <= ~iHold;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    oDone   <= 1'b0;
                    oEn     <= 1'b0;
                    oReady  <= 1'b1;
                    oBusy   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= ZERO_V;
                    oReady  <= 1'b1;
                    oEn     <= 1'b0;
                    oBusy   <= 1'b0;
                    oDone   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_stream_encoder.sv
// Table-driven bench for bit_stream_encoder (data_width=3) with hold and abort sequences.
// Expected strobe count for -4 follows BSENC_SYM_CLAMP_EN.
module tb_bit_stream_encoder;

    logic       iClk;
    logic       iRst;
    logic [2:0] iData;
    logic       iValid;
    logic       oReady;
    logic       iHold;
    logic       oBit;
    logic       oEn;
    logic       oBusy;
    logic       oDone;

    int errCnt = 0;
    int chkCnt = 0;
    int summ   = 0;

    typedef struct {
        logic [2:0] data;
        int         steps;
        logic       bitv;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    bit_stream_encoder #(.data_width(3)) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iData (iData),
        .iValid(iValid),
        .oReady(oReady),
        .iHold (iHold),
        .oBit  (oBit),
        .oEn   (oEn),
        .oBusy (oBusy),
        .oDone (oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        chkCnt++;
        if (act != exp) begin
            errCnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (!oReady && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", int'(oReady), 1);
    endtask

    // Accept one word, count strobes until oDone, update the summ model
    task automatic runWord(input logic [2:0] d, input int expSteps, input logic expBit,
                           input int expLat, input string tag);
        int strobes;
        int badBits;
        int lat;
        int cyc;
        waitReady();
        iData  = d;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        strobes = 0;
        badBits = 0;
        lat     = -1;
        chk({tag, "_busy"}, int'(oBusy), 1);
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (oEn) begin
                strobes++;
                if (oBit != expBit) badBits++;
                if (oBit) summ = (summ < 3) ? summ + 1 : summ;
                else      summ = (summ > -3) ? summ - 1 : summ;
            end
            if (oDone) begin
                lat = cyc;
                break;
            end
            tick();
        end
        chk({tag, "_strobes"}, strobes, expSteps);
        chk({tag, "_bit"}, badBits, 0);
        chk({tag, "_donelat"}, lat, expLat);
        tick();
        chk({tag, "_ready_after"}, int'(oReady), 1);
        chk({tag, "_idle_busy"}, int'(oBusy), 0);
    endtask

    initial begin
        int strobes;
        int lat;
        int enSeen;
        vecs[0] = '{3'b011, 3, 1'b1, 4};
        vecs[1] = '{3'b110, 2, 1'b0, 3};
        vecs[2] = '{3'b000, 0, 1'b1, 1};
        vecs[3] = '{3'b001, 1, 1'b1, 2};
        vecs[4] = '{3'b111, 1, 1'b0, 2};
        vecs[5] = '{3'b101, 3, 1'b0, 4};
        vecs[6] = '{3'b010, 2, 1'b1, 3};
`ifdef BSENC_SYM_CLAMP_EN
        vecs[7] = '{3'b100, 3, 1'b0, 4};
`else
        vecs[7] = '{3'b100, 4, 1'b0, 5};
`endif

        iRst   = 1'b1;
        iData  = 3'b000;
        iValid = 1'b0;
        iHold  = 1'b0;
        tick();
        tick();
        chk("rst_ready", int'(oReady), 1);
        chk("rst_en",    int'(oEn),    0);
        chk("rst_busy",  int'(oBusy),  0);
        chk("rst_done",  int'(oDone),  0);
        chk("rst_bit",   int'(oBit),   0);
        iRst = 1'b0;
        tick();

        summ = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) summ = 1;
            runWord(vecs[i].data, vecs[i].steps, vecs[i].bitv, vecs[i].lat,
                    $sformatf("vec%0d", i));
            if (i == 0) chk("summ_plus3", summ, 3);
            if (i == 1) chk("summ_minus2", summ, -1);
        end

        // Hold for two cycles after the first step; a second word during the burst is dropped
        waitReady();
        iData  = 3'b011;
        iValid = 1'b1;
        tick();
        iData  = 3'b001;
        strobes = 0;
        lat     = -1;
        chk("hold_first_en", int'(oEn), 1);
        if (oEn) strobes++;
        iHold = 1'b1;
        tick();
        chk("hold_en_low1", int'(oEn), 0);
        tick();
        chk("hold_en_low2", int'(oEn), 0);
        iHold  = 1'b0;
        iValid = 1'b0;
        for (int cyc = 3; cyc <= 20; cyc++) begin
            if (oEn) strobes++;
            if (oDone) begin
                lat = cyc;
                break;
            end
            tick();
        end
        chk("hold_strobes", strobes, 3);
        chk("hold_donelat", lat, 6);
        tick();
        enSeen = 0;
        for (int k = 0; k < 6; k++) begin
            if (oEn) enSeen++;
            tick();
        end
        chk("hold_no_queued_word", enSeen, 0);

        // Reset mid-burst on -4 aborts remaining steps
        waitReady();
        iData  = 3'b100;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        chk("abort_en1", int'(oEn), 1);
        tick();
        chk("abort_en2", int'(oEn), 1);
        iRst = 1'b1;
        tick();
        chk("abort_en_off", int'(oEn), 0);
        chk("abort_ready",  int'(oReady), 1);
        iRst = 1'b0;
        enSeen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (oEn) enSeen++;
        end
        chk("abort_no_more_en", enSeen, 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
